hex_text_writer: RTL

- Sequencer that renders a binary word as hexadecimal glyph codes into the OSD/debug text RAM, one character per write.
- Accepts a value and a text-RAM base address over a valid/ready request port, then walks the nibbles MSB-first through a nibble-to-glyph lookup.
- Drives a write port that the consumer can back-pressure.
- Sits between debug/status sources (register snoopers, counters) and the text-overlay character RAM.

---
 rtl/hex_text_writer_pkg.sv | 28 ++
 rtl/hex_text_writer_if.sv | 30 +++
 rtl/hex_text_writer_glyph.sv | 20 ++
 rtl/hex_text_writer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/hex_text_writer_pkg.sv
// hex_text_pkg: shared definitions for the hex text writer.
//   - Glyph codes used by the OSD text RAM character set.
//   - FSM state enumeration (PREFIX only used when HEX_WRITER_PREFIX_EN is defined).
//   - Helpers that derive digit count and counter width from the value width.
package hex_text_pkg;

  localparam logic [7:0] GLYPH_DIGIT0  = 8'd16;
  localparam logic [7:0] GLYPH_ALPHA_A = 8'd33;
  localparam logic [7:0] GLYPH_SPACE   = 8'd0;
  localparam logic [7:0] GLYPH_X       = 8'd88;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_PREFIX = 2'd2
  } hex_state_e;

  // Number of hex digits needed for a value of the given width.
  function automatic int nib_count(int data_w);
    return data_w / 4;
  endfunction

  // Digit counter width; a single-digit value still needs a 1-bit counter.
  function automatic int cnt_width(int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/hex_text_writer_if.sv
// hex_text_writer_if: request and character-write bundle of the hex text writer.
//   Request side : req_valid, req_ready, req_value[DATA_W], req_addr[ADDR_W]
//   Write side   : wr_en, wr_ready, wr_addr[ADDR_W], wr_data[8]
//   Status       : busy, done
// Modports: slave = the writer itself, master = the requester / text RAM side.
interface hex_text_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_value;
  logic [ADDR_W-1:0] req_addr;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;

  modport slave (
    input  req_valid, req_value, req_addr, wr_ready,
    output req_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport master (
    output req_valid, req_value, req_addr, wr_ready,
    input  req_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/hex_text_writer_glyph.sv
// hex_digit_glyph: combinational map from one hex nibble to its text RAM glyph code.
//   nib_i   [4] : nibble value 0..15
//   glyph_o [8] : 0-9 -> 16..25, A-F -> 33..38
module hex_digit_glyph
  import hex_text_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] glyph_o
);

  // Digits and letters occupy two separate contiguous runs in the character set.
  always_comb begin
    if (nib_i < 4'd10) begin
      glyph_o = GLYPH_DIGIT0 + {4'b0000, nib_i};
    end else begin
      glyph_o = GLYPH_ALPHA_A + {4'b0000, nib_i} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_text_writer.sv
// hex_text_writer: renders a DATA_W-bit value as hex glyphs into the text RAM,
// one character per accepted write, most significant nibble first.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : hex_text_writer_if.slave (request port, write port, busy/done)
// Optional: define HEX_WRITER_PREFIX_EN to emit "0x" before the digits.
module hex_text_writer
  import hex_text_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
)(
  input  logic               clk,
  input  logic               reset,
  hex_text_writer_if.slave   bus
);

  localparam int NIB   = nib_count(DATA_W);
  localparam int CNT_W = cnt_width(NIB);

  localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] S_EMIT   = 2'(ST_EMIT);
`ifdef HEX_WRITER_PREFIX_EN
  localparam logic [1:0] S_PREFIX = 2'(ST_PREFIX);
`endif

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              done_q,  done_d;
`ifdef HEX_WRITER_PREFIX_EN
  logic              pfx_q,   pfx_d;
`endif

  logic [7:0] digit_glyph;
  logic       active;

  hex_digit_glyph u_glyph (
    .nib_i   (shift_q[DATA_W-1 -: 4]),
    .glyph_o (digit_glyph)
  );

  // Outputs are forced quiet while reset is asserted so an aborted
  // request cannot complete a write in the reset cycle.
  assign active        = (state_q != S_IDLE) && !reset;
  assign bus.req_ready = (state_q == S_IDLE) && !reset;
  assign bus.busy      = active;
  assign bus.wr_en     = active;
  assign bus.wr_addr   = active ? addr_q : '0;
  assign bus.done      = done_q && !reset;

  // Character currently presented on the write port.
  always_comb begin
    bus.wr_data = GLYPH_SPACE;
    if (active) begin
      bus.wr_data = digit_glyph;
`ifdef HEX_WRITER_PREFIX_EN
      if (state_q == S_PREFIX) begin
        bus.wr_data = pfx_q ? GLYPH_X : GLYPH_DIGIT0;
      end
`endif
    end
  end

  // Sequencer: every accepted write advances address; digits also shift
  // and count down, and the last digit returns to IDLE with a done pulse.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef HEX_WRITER_PREFIX_EN
    pfx_d   = pfx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          shift_d = bus.req_value;
          addr_d  = bus.req_addr;
          cnt_d   = CNT_W'(NIB - 1);
`ifdef HEX_WRITER_PREFIX_EN
          pfx_d   = 1'b0;
          state_d = S_PREFIX;
`else
          state_d = S_EMIT;
`endif
        end
      end
      S_EMIT: begin
        if (bus.wr_ready) begin
          shift_d = shift_q << 4;
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
`ifdef HEX_WRITER_PREFIX_EN
      S_PREFIX: begin
        if (bus.wr_ready) begin
          addr_d = addr_q + 1'b1;
          pfx_d  = 1'b1;
          if (pfx_q) begin
            state_d = S_EMIT;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef HEX_WRITER_PREFIX_EN
      pfx_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef HEX_WRITER_PREFIX_EN
      pfx_q   <= pfx_d;
`endif
    end
  end

endmodule
